// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: FSM state codes, round length and
// the widths used by the seconds counter and its BCD display form.
package game_pkg;

  localparam int SEC_W = 6;
  localparam int BCD_W = 4;
  localparam int DEFAULT_GAME_SECONDS = 30;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COUNTING = 2'd1;
  localparam logic [1:0] PAUSED   = 2'd2;
  localparam logic [1:0] EXPIRED  = 2'd3;

  // Constant-only conversion (reset/reload values); the runtime count never divides.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned value);
    return {BCD_W'(value / 10), BCD_W'(value % 10)};
  endfunction

endpackage

// File: rtl/tick_sync.sv
// N-stage synchroniser for a slow asynchronous level, followed by a one-cycle
// strobe on each synchronised rising edge.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic clkIn,
  input  logic reset,
  input  logic async_in,
  output logic strobe
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("tick_sync: STAGES must be at least 2");
    end
  endgenerate

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Strobe is live the cycle after the last stage rises, consumed on the next edge.
  assign strobe = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// Round countdown driven by the 1 Hz incrementClk: start/restart, pause,
// expiry level/strobe, BCD copy of the count and a final-seconds warning.
module countdown_timer
  import game_pkg::*;
#(
  parameter int GAME_SECONDS = DEFAULT_GAME_SECONDS,
  parameter int WARN_SECONDS = 5,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             incrementClk,
  input  logic             start,
  input  logic             pause,
  output logic             timer_expired,
  output logic             expired_pulse,
  output logic [SEC_W-1:0] seconds_left,
  output logic [7:0]       seconds_bcd,
  output logic             warning,
  output logic             running,
  output logic [1:0]       state
);

  generate
    if (GAME_SECONDS < 1 || GAME_SECONDS > 59) begin : g_bad_game
      $error("countdown_timer: GAME_SECONDS must be 1..59");
    end
    if (WARN_SECONDS < 0 || WARN_SECONDS >= GAME_SECONDS) begin : g_bad_warn
      $error("countdown_timer: WARN_SECONDS must be below GAME_SECONDS");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("countdown_timer: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam logic [SEC_W-1:0] GAME_SEC = SEC_W'(GAME_SECONDS);
  localparam logic [SEC_W-1:0] WARN_SEC = SEC_W'(WARN_SECONDS);
  localparam logic [7:0]       GAME_BCD = to_bcd(GAME_SECONDS);

  logic             tick;
  logic [1:0]       state_d;
  logic [SEC_W-1:0] sec_d;
  logic [7:0]       bcd_d;
  logic             expired_d;
  logic             pulse_d;
  logic             warning_d;

  tick_sync #(.STAGES(SYNC_STAGES)) u_tick_sync (
    .clkIn    (clkIn),
    .reset    (reset),
    .async_in (incrementClk),
    .strobe   (tick)
  );

  always_comb begin
    state_d   = state;
    sec_d     = seconds_left;
    bcd_d     = seconds_bcd;
    expired_d = timer_expired;
    pulse_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = COUNTING;
          sec_d   = GAME_SEC;
          bcd_d   = GAME_BCD;
        end
      end
      COUNTING: begin
        // pause outranks a coincident tick, which is simply dropped
        if (pause) begin
          state_d = PAUSED;
        end else if (tick && seconds_left > 1) begin
          sec_d = seconds_left - 1'b1;
          if (seconds_bcd[3:0] == 4'd0) bcd_d = {seconds_bcd[7:4] - 4'd1, 4'd9};
          else                          bcd_d = {seconds_bcd[7:4], seconds_bcd[3:0] - 4'd1};
        end else if (tick && seconds_left == 1) begin
          sec_d     = '0;
          bcd_d     = 8'h00;
          state_d   = EXPIRED;
          expired_d = 1'b1;
          pulse_d   = 1'b1;
        end
      end
      PAUSED: begin
        if (!pause) state_d = COUNTING;
      end
      default: begin
        if (start) begin
          state_d   = COUNTING;
          sec_d     = GAME_SEC;
          bcd_d     = GAME_BCD;
          expired_d = 1'b0;
        end
      end
    endcase
  end

  // Derived from next-state values so the registered flags line up with the count.
  assign warning_d = ((state_d == COUNTING) || (state_d == PAUSED)) &&
                     (sec_d != '0) && (sec_d <= WARN_SEC);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      seconds_left  <= GAME_SEC;
      seconds_bcd   <= GAME_BCD;
      timer_expired <= 1'b0;
      expired_pulse <= 1'b0;
      warning       <= 1'b0;
      running       <= 1'b0;
    end else begin
      state         <= state_d;
      seconds_left  <= sec_d;
      seconds_bcd   <= bcd_d;
      timer_expired <= expired_d;
      expired_pulse <= pulse_d;
      warning       <= warning_d;
      running       <= (state_d == COUNTING);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer against a second-level model of the
// round (state, seconds remaining) with randomised tick spacing and pauses.
module tb_countdown_timer;

  localparam int GAME = 30;
  localparam int WARN = 5;
  localparam int SYNC = 2;

  logic       clkIn = 1'b0;
  logic       reset = 1'b0;
  logic       incrementClk = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       timer_expired;
  logic       expired_pulse;
  logic [5:0] seconds_left;
  logic [7:0] seconds_bcd;
  logic       warning;
  logic       running;
  logic [1:0] state;

  countdown_timer #(
    .GAME_SECONDS (GAME),
    .WARN_SECONDS (WARN),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clkIn         (clkIn),
    .reset         (reset),
    .incrementClk  (incrementClk),
    .start         (start),
    .pause         (pause),
    .timer_expired (timer_expired),
    .expired_pulse (expired_pulse),
    .seconds_left  (seconds_left),
    .seconds_bcd   (seconds_bcd),
    .warning       (warning),
    .running       (running),
    .state         (state)
  );

  always #5 clkIn = ~clkIn;

  // {state, seconds_left, seconds_bcd, warning, running, timer_expired, expired_pulse}
  logic [19:0] obs_vec;
  assign obs_vec = {state, seconds_left, seconds_bcd, warning, running, timer_expired, expired_pulse};

  int total = 0;
  int bad = 0;

  // Model: 0 idle, 1 counting, 2 paused, 3 expired; seconds as a plain integer.
  int m_state;
  int m_sec;
  logic [19:0] pre_obs, post_obs, after_obs, exp_pre;

  function automatic logic [19:0] exp_vec(input bit p);
    logic [7:0] b;
    logic       w;
    b = 8'(((m_sec / 10) * 16) + (m_sec % 10));
    w = (m_state == 1 || m_state == 2) && m_sec >= 1 && m_sec <= WARN;
    return {2'(m_state), 6'(m_sec), b, w, m_state == 1, m_state == 3, p};
  endfunction

  function automatic void m_reset();
    m_state = 0;
    m_sec   = GAME;
  endfunction

  function automatic void m_start();
    if (m_state == 0 || m_state == 3) begin
      m_state = 1;
      m_sec   = GAME;
    end
  endfunction

  function automatic void m_pause(input bit p);
    if (p && m_state == 1) m_state = 2;
    else if (!p && m_state == 2) m_state = 1;
  endfunction

  function automatic bit m_tick();
    if (m_state == 1) begin
      if (m_sec > 1) begin
        m_sec = m_sec - 1;
      end else begin
        m_sec   = 0;
        m_state = 3;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clkIn) reset = 1'b0;
    pause = 1'b0;
    m_reset();
    @(negedge clkIn) reset = 1'b1;
    @(negedge clkIn);
  endtask

  task automatic pulse_start();
    @(negedge clkIn) start = 1'b1;
    @(negedge clkIn) start = 1'b0;
    m_start();
  endtask

  task automatic set_pause(input bit p);
    @(negedge clkIn) pause = p;
    @(negedge clkIn);
    m_pause(p);
  endtask

  // One incrementClk period. Captures outputs just before, on, and one cycle
  // after the edge where the synchronised tick lands (SYNC+1 edges after the rise).
  task automatic do_tick(input bit pause_with);
    @(negedge clkIn) incrementClk = 1'b1;
    repeat (SYNC) @(negedge clkIn);
    pre_obs = obs_vec;
    if (pause_with) pause = 1'b1;
    @(negedge clkIn) post_obs = obs_vec;
    @(negedge clkIn) after_obs = obs_vec;
    incrementClk = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clkIn);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick(1'b0);
      void'(m_tick());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_reset();
    repeat (3) @(negedge clkIn);
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL reset_values: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    @(negedge clkIn) reset = 1'b1;
    do_tick(1'b0);
    void'(m_tick());
    total++;
    if (post_obs !== exp_vec(1'b0)) begin
      bad++; $display("FAIL idle_tick: got %h want %h", post_obs, exp_vec(1'b0));
    end
  endtask

  task automatic test_full_round();
    bit p;
    int pulses;
    pulses = 0;
    pulse_start();
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL round_start: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    for (int i = 0; i < GAME; i++) begin
      exp_pre = exp_vec(1'b0);
      do_tick(1'b0);
      p = m_tick();
      pulses += int'(post_obs[0]) + int'(after_obs[0]);
      total++;
      if (pre_obs !== exp_pre) begin
        bad++; $display("FAIL round_latency%0d: got %h want %h", i, pre_obs, exp_pre);
      end
      total++;
      if (post_obs !== exp_vec(p)) begin
        bad++; $display("FAIL round_tick%0d: got %h want %h", i, post_obs, exp_vec(p));
      end
      total++;
      if (after_obs !== exp_vec(1'b0)) begin
        bad++; $display("FAIL round_after%0d: got %h want %h", i, after_obs, exp_vec(1'b0));
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL expired_pulse_count: got %0d want 1", pulses);
    end
    do_tick(1'b0);
    void'(m_tick());
    total++;
    if (post_obs !== exp_vec(1'b0)) begin
      bad++; $display("FAIL tick_at_zero: got %h want %h", post_obs, exp_vec(1'b0));
    end
  endtask

  task automatic test_restart();
    pulse_start();
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL restart_from_expired: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    advance(GAME - 17);
    pulse_start();
    total++;
    if (obs_vec !== exp_vec(1'b0) || seconds_left !== 6'd17) begin
      bad++; $display("FAIL start_while_counting: got %h want %h", obs_vec, exp_vec(1'b0));
    end
  endtask

  task automatic test_pause();
    int k;
    do_reset();
    pulse_start();
    advance(GAME - 20);
    set_pause(1'b1);
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL pause_enter: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    k = $urandom_range(3, 5);
    for (int i = 0; i < k; i++) begin
      do_tick(1'b0);
      void'(m_tick());
      total++;
      if (post_obs !== exp_vec(1'b0)) begin
        bad++; $display("FAIL paused_tick%0d: got %h want %h", i, post_obs, exp_vec(1'b0));
      end
    end
    pulse_start();
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL start_while_paused: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    set_pause(1'b0);
    do_tick(1'b0);
    void'(m_tick());
    total++;
    if (post_obs !== exp_vec(1'b0) || seconds_left !== 6'd19) begin
      bad++; $display("FAIL resume_tick: got %h want %h", post_obs, exp_vec(1'b0));
    end
  endtask

  task automatic test_pause_with_tick();
    advance(19 - 12);
    do_tick(1'b1);
    m_pause(1'b1);
    void'(m_tick());
    total++;
    if (post_obs !== exp_vec(1'b0) || seconds_left !== 6'd12) begin
      bad++; $display("FAIL pause_coincident_tick: got %h want %h", post_obs, exp_vec(1'b0));
    end
    set_pause(1'b0);
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL pause_release: got %h want %h", obs_vec, exp_vec(1'b0));
    end
  endtask

  task automatic test_reset_mid_round();
    advance(12 - 8);
    @(negedge clkIn);
    #2 reset = 1'b0;
    #1 m_reset();
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs_vec, exp_vec(1'b0));
    end
    @(negedge clkIn) reset = 1'b1;
    do_tick(1'b0);
    void'(m_tick());
    total++;
    if (post_obs !== exp_vec(1'b0)) begin
      bad++; $display("FAIL tick_after_reset: got %h want %h", post_obs, exp_vec(1'b0));
    end
    pulse_start();
    total++;
    if (obs_vec !== exp_vec(1'b0)) begin
      bad++; $display("FAIL start_after_reset: got %h want %h", obs_vec, exp_vec(1'b0));
    end
  endtask

  task automatic test_random_round();
    bit p;
    bit pw;
    int steps;
    do_reset();
    pulse_start();
    steps = 0;
    while (m_state != 3 && steps < 200) begin
      steps++;
      if ($urandom_range(0, 5) == 0) begin
        set_pause(!pause);
        total++;
        if (obs_vec !== exp_vec(1'b0)) begin
          bad++; $display("FAIL rand_pause%0d: got %h want %h", steps, obs_vec, exp_vec(1'b0));
        end
      end else begin
        pw = !pause && ($urandom_range(0, 9) == 0);
        do_tick(pw);
        if (pw) m_pause(1'b1);
        p = m_tick();
        total++;
        if (post_obs !== exp_vec(p)) begin
          bad++; $display("FAIL rand_tick%0d: got %h want %h", steps, post_obs, exp_vec(p));
        end
      end
    end
    total++;
    if (timer_expired !== 1'b1) begin
      bad++; $display("FAIL rand_round_end: got %b want 1", timer_expired);
    end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_restart();
    test_pause();
    test_pause_with_tick();
    test_reset_mid_round();
    test_random_round();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
